uart_tx: RTL and testbench

UART transmit control block, the transmit-side counterpart of the UART receiver inside the UART APB peripheral. It takes bytes written to the TX data register, buffers them, and serialises each one onto `UART_TX` as start, data LSB-first, optional parity and stop bits. Bit timing comes from the shared 16x oversample pulse of the UART baud generator.

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_tx_sync_fifo.sv | 65 ++++++
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: widths, oversample ratio,
// FSM state encoding, per-frame format record and the parity helper.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_WIDTH        = 8;
  localparam int unsigned UART_TX_FIFO_DEPTH     = 8;
  localparam int unsigned UART_TX_FIFO_PTR_WIDTH = $clog2(UART_TX_FIFO_DEPTH);
  localparam int unsigned UART_OVERSAMPLE        = 16;
  localparam int unsigned SAMPLE_CNT_W           = $clog2(UART_OVERSAMPLE);
  localparam int unsigned BIT_CNT_W              = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Frame format captured when a byte is popped; held for the whole frame.
  typedef struct packed {
    logic data_bits;   // 0 = 7 bits, 1 = 8 bits
    logic parity_en;
    logic parity_bit;  // precomputed value driven in PARITY
  } tx_frame_cfg_t;

  // Even parity = XOR of transmitted bits; bit 7 only counts in 8-bit mode.
  function automatic logic tx_parity(input logic [UART_DATA_WIDTH-1:0] data,
                                     input logic data_bits,
                                     input logic odd0_even1);
    logic x;
    x = (^data[UART_DATA_WIDTH-2:0]) ^ (data_bits & data[UART_DATA_WIDTH-1]);
    return odd0_even1 ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO used as the TX byte buffer (depth must be a power of two).
// Ports: clk/rst_n, i_push/i_wdata write side, i_pop/o_rdata read side
// (first-word fall-through), o_full/o_empty registered status flags.
module uart_tx_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx.sv
// UART transmit controller: buffers bytes from the TX data register and
// serialises them as start, LSB-first data (7/8), optional parity, stop.
// Bit timing: 16 tx_sample_pulse periods per bit.
// Build option: define UART_TX_FIFO_EN for a UART_TX_FIFO_DEPTH-entry FIFO;
// otherwise a single holding register buffers the next byte.
// Ports: PCLK/PRESETN, tx_sample_pulse, data_bits/parity_en/parity_odd0_even1
// (format, latched per frame), tx_data_reg_wr/tx_data (write), UART_TX (line),
// tx_ready (not full), tx_busy (not idle), tx_done and overflow (pulses).
module uart_tx
  import uart_tx_pkg::*;
(
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic                       tx_sample_pulse,
  input  logic                       data_bits,
  input  logic                       parity_en,
  input  logic                       parity_odd0_even1,
  input  logic                       tx_data_reg_wr,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  output logic                       UART_TX,
  output logic                       tx_ready,
  output logic                       tx_busy,
  output logic                       tx_done,
  output logic                       overflow
);

  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [UART_DATA_WIDTH-1:0] w_rd_data;
  logic                       w_baud;

  uart_state_e                r_state, w_state_nxt;
  logic [SAMPLE_CNT_W-1:0]    r_sample_cnt, w_sample_cnt_nxt;
  logic [BIT_CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [UART_DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  tx_frame_cfg_t              r_cfg, w_cfg_nxt;
  logic                       r_uart_tx, w_uart_tx_nxt;
  logic                       r_tx_done, w_tx_done_nxt;
  logic                       r_busy;
  logic                       r_overflow;

  // A pop in IDLE frees a slot in the same cycle, so a write on full is kept.
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;
  assign w_push = tx_data_reg_wr && (!w_full || w_pop);
  assign w_baud = tx_sample_pulse && (r_sample_cnt == SAMPLE_CNT_W'(UART_OVERSAMPLE - 1));

`ifdef UART_TX_FIFO_EN
  uart_tx_sync_fifo #(
    .DEPTH (UART_TX_FIFO_DEPTH),
    .WIDTH (UART_DATA_WIDTH),
    .PTR_W (UART_TX_FIFO_PTR_WIDTH)
  ) uart_tx_buf (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .i_push  (w_push),
    .i_wdata (tx_data),
    .i_pop   (w_pop),
    .o_rdata (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`else
  logic [UART_DATA_WIDTH-1:0] r_hold;
  logic                       r_hold_vld;

  // Holding register; emptied at frame start so the next byte can load early.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold     <= tx_data;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end

  assign w_rd_data = r_hold;
  assign w_full    = r_hold_vld;
  assign w_empty   = !r_hold_vld;
`endif

  // Next-state, datapath and registered-line value.
  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_cfg_nxt        = r_cfg;
    w_tx_done_nxt    = 1'b0;
    w_uart_tx_nxt    = 1'b1;

    if (r_state == ST_IDLE) begin
      w_sample_cnt_nxt = '0;
    end else if (tx_sample_pulse) begin
      w_sample_cnt_nxt = r_sample_cnt + SAMPLE_CNT_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_shift_nxt          = w_rd_data;
          w_bit_cnt_nxt        = '0;
          w_cfg_nxt.data_bits  = data_bits;
          w_cfg_nxt.parity_en  = parity_en;
          w_cfg_nxt.parity_bit = tx_parity(w_rd_data, data_bits, parity_odd0_even1);
          w_state_nxt          = ST_START;
        end
      end
      ST_START: begin
        if (w_baud) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_baud) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (r_bit_cnt == BIT_CNT_W'(6) + BIT_CNT_W'(r_cfg.data_bits)) begin
            w_state_nxt = r_cfg.parity_en ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_baud) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_baud) begin
          w_tx_done_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level tracks the state being entered so UART_TX is a flop output.
    case (w_state_nxt)
      ST_START:  w_uart_tx_nxt = 1'b0;
      ST_DATA:   w_uart_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_uart_tx_nxt = w_cfg_nxt.parity_bit;
      default:   w_uart_tx_nxt = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_cfg        <= '0;
      r_uart_tx    <= 1'b1;
      r_tx_done    <= 1'b0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_cfg        <= w_cfg_nxt;
      r_uart_tx    <= w_uart_tx_nxt;
      r_tx_done    <= w_tx_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_overflow   <= tx_data_reg_wr && w_full && !w_pop;
    end
  end

  assign UART_TX  = r_uart_tx;
  assign tx_ready = !w_full;
  assign tx_busy  = r_busy;
  assign tx_done  = r_tx_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps drive bytes and formats,
// a scoreboard queue holds expected frames, and a line monitor decodes them.
module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic       PCLK;
  logic       PRESETN;
  logic       tx_sample_pulse;
  logic       data_bits;
  logic       parity_en;
  logic       parity_odd0_even1;
  logic       tx_data_reg_wr;
  logic [7:0] tx_data;
  logic       UART_TX;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       overflow;

  uart_tx u_dut (
    .PCLK              (PCLK),
    .PRESETN           (PRESETN),
    .tx_sample_pulse   (tx_sample_pulse),
    .data_bits         (data_bits),
    .parity_en         (parity_en),
    .parity_odd0_even1 (parity_odd0_even1),
    .tx_data_reg_wr    (tx_data_reg_wr),
    .tx_data           (tx_data),
    .UART_TX           (UART_TX),
    .tx_ready          (tx_ready),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .overflow          (overflow)
  );

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       pen;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_frames = 0;
  int   n_done   = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One-cycle oversample pulse every 4 clocks, changing away from both edges.
  initial begin
    tx_sample_pulse = 1'b0;
    forever begin
      repeat (3) @(posedge PCLK);
      #2 tx_sample_pulse = 1'b1;
      @(posedge PCLK);
      #2 tx_sample_pulse = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int nbits, input logic pen, input logic even);
    exp_t e;
    logic x;
    x = 1'b0;
    for (int i = 0; i < nbits; i++) x = x ^ d[i];
    e.data  = d;
    e.nbits = nbits;
    e.pen   = pen;
    e.par   = even ? x : ~x;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    tx_data        = d;
    tx_data_reg_wr = 1'b1;
    step(1);
    tx_data_reg_wr = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || tx_busy) && t < 20000) begin
      step(1);
      t++;
    end
    chk("drain", 32'(sb.size() == 0 && !tx_busy), 1);
  endtask

  // Line monitor: sample each bit mid-period by counting oversample pulses.
  logic        in_frame = 1'b0;
  logic        unexp;
  int          pcnt;
  logic [15:0] lb;
  exp_t        cur;

  always @(negedge PCLK) begin
    if (!PRESETN) begin
      in_frame = 1'b0;
    end else begin
      if (tx_done) n_done++;
      if (in_frame && tx_done) begin
        logic [7:0] d;
        logic [7:0] mask;
        d    = 8'h00;
        mask = (cur.nbits == 7) ? 8'h7f : 8'hff;
        for (int i = 0; i < cur.nbits; i++) d[i] = lb[1+i];
        chk("frame_len", 32'(pcnt), 32'(16 * (2 + cur.nbits + int'(cur.pen))));
        chk("start_bit", 32'(lb[0]), 0);
        chk("data", 32'(d), 32'(cur.data & mask));
        if (cur.pen) chk("parity", 32'(lb[1+cur.nbits]), 32'(cur.par));
        chk("stop_bit", 32'(lb[1+cur.nbits+int'(cur.pen)]), 1);
        n_frames++;
        if (!unexp) void'(sb.pop_front());
        in_frame = 1'b0;
      end else if (!in_frame && tx_done) begin
        chk("stray_done", 32'(tx_done), 0);
      end
      if (!in_frame && !tx_done && UART_TX === 1'b0) begin
        chk("frame_expected", 32'(sb.size() != 0), 1);
        unexp = (sb.size() == 0);
        if (unexp) begin
          cur.data = 8'h00; cur.nbits = 8; cur.pen = 1'b0; cur.par = 1'b0;
        end else begin
          cur = sb[0];
        end
        in_frame = 1'b1;
        pcnt     = 0;
        lb       = '1;
      end
      if (in_frame && !tx_done && tx_sample_pulse) begin
        pcnt++;
        if (pcnt % 16 == 8 && pcnt / 16 < 16) lb[pcnt/16] = UART_TX;
      end
    end
  end

  initial begin
    int ovf;
    int acc;
    int t;
    int base;

    PRESETN           = 1'b0;
    data_bits         = 1'b1;
    parity_en         = 1'b0;
    parity_odd0_even1 = 1'b0;
    tx_data_reg_wr    = 1'b0;
    tx_data           = 8'h00;
    step(2);
    chk("rst_uart_tx",  32'(UART_TX), 1);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_tx_busy",  32'(tx_busy), 0);
    chk("rst_tx_done",  32'(tx_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    PRESETN = 1'b1;
    step(3);

    // 8N1 0xA5 with first-frame latency
    base = n_done;
    push_exp(8'hA5, 8, 1'b0, 1'b0);
    wr(8'hA5);
    chk("lat_c1_line", 32'(UART_TX), 1);
    chk("lat_c1_busy", 32'(tx_busy), 0);
    step(1);
    chk("lat_c2_line", 32'(UART_TX), 0);
    chk("lat_c2_busy", 32'(tx_busy), 1);
    drain();
    chk("done_once", 32'(n_done - base), 1);

    // 8E1 / 8O1 0x03, 7E1 0xFF
    parity_en = 1'b1; parity_odd0_even1 = 1'b1;
    push_exp(8'h03, 8, 1'b1, 1'b1); wr(8'h03); drain();
    parity_odd0_even1 = 1'b0;
    push_exp(8'h03, 8, 1'b1, 1'b0); wr(8'h03); drain();
    data_bits = 1'b0; parity_odd0_even1 = 1'b1;
    push_exp(8'hFF, 7, 1'b1, 1'b1); wr(8'hFF); drain();
    data_bits = 1'b1; parity_en = 1'b0; parity_odd0_even1 = 1'b0;

    // Nine back-to-back writes from idle; first pop frees one slot
    chk("ready_pre_burst", 32'(tx_ready), 1);
    acc = (CAP + 1 < 9) ? CAP + 1 : 9;
    for (int i = 0; i < acc; i++) push_exp(8'(i), 8, 1'b0, 1'b0);
    ovf = 0;
    for (int i = 0; i < 9; i++) begin
      tx_data        = 8'(i);
      tx_data_reg_wr = 1'b1;
      step(1);
      if (overflow) ovf++;
    end
    tx_data_reg_wr = 1'b0;
    chk("burst_overflows", 32'(ovf), 32'(9 - acc));
    chk("ready_full", 32'(tx_ready), 0);
    wr(8'hEE);
    chk("ovf_on_full", 32'(overflow), 1);
    step(1);
    chk("ovf_one_cycle", 32'(overflow), 0);

    // Write on full in the pop cycle that follows a stop bit
    t = 0;
    while (!tx_done && t < 2000) begin
      step(1);
      t++;
    end
    chk("done_seen", 32'(tx_done), 1);
    chk("full_at_pop", 32'(tx_ready), 0);
    push_exp(8'hC3, 8, 1'b0, 1'b0);
    wr(8'hC3);
    chk("no_ovf_with_pop", 32'(overflow), 0);
    drain();

    // Format change mid-frame affects only the next frame
    base = n_frames;
    push_exp(8'h3C, 8, 1'b0, 1'b0);
    push_exp(8'h5B, 8, 1'b1, 1'b1);
    wr(8'h3C);
    wr(8'h5B);
    step(100);
    parity_en = 1'b1; parity_odd0_even1 = 1'b1;
    drain();
    chk("toggle_frames", 32'(n_frames - base), 2);
    parity_en = 1'b0; parity_odd0_even1 = 1'b0;

    // Reset in the middle of data bit 1 (a zero) of 0x55
    push_exp(8'h55, 8, 1'b0, 1'b0);
    wr(8'h55);
    t = 0;
    while (UART_TX !== 1'b0 && t < 200) begin
      step(1);
      t++;
    end
    step(160);
    chk("pre_reset_line", 32'(UART_TX), 0);
    #2 PRESETN = 1'b0;
    #1;
    chk("rst_async_line", 32'(UART_TX), 1);
    chk("rst_async_busy", 32'(tx_busy), 0);
    chk("rst_async_ready", 32'(tx_ready), 1);
    sb.delete();
    step(3);
    PRESETN = 1'b1;
    base = n_frames;
    step(400);
    chk("no_frame_after_rst", 32'(n_frames - base), 0);
    chk("idle_line_after_rst", 32'(UART_TX), 1);
    chk("idle_busy_after_rst", 32'(tx_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
